// File: rtl/score_increment_sequencer.sv
// Turns multi-point score events into one enable pulse per point for a BCD score updater.
// Optional build macro SCORE_SATURATE_EN: accept every event, saturate pending, flag drops.
module score_increment_sequencer #(
  parameter int POINTS_WIDTH  = 4,
  parameter int PENDING_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     addValid,
  input  logic [POINTS_WIDTH-1:0]  addPoints,
  output logic                     addReady,
  input  logic                     counterReady,
  output logic                     incEnable,
  output logic [PENDING_WIDTH-1:0] pending,
`ifdef SCORE_SATURATE_EN
  output logic                     pointsDropped,
`endif
  output logic                     busy
);

  typedef enum logic [0:0] {
    ST_ARM  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [PENDING_WIDTH-1:0] PEND_MAX   = {PENDING_WIDTH{1'b1}};
  localparam logic [PENDING_WIDTH:0]   PEND_MAX_W = {1'b0, {PENDING_WIDTH{1'b1}}};
  localparam logic [PENDING_WIDTH:0]   PTS_MAX_W  = (PENDING_WIDTH+1)'({POINTS_WIDTH{1'b1}});

  state_t                   r_state;
  state_t                   w_next_state;
  logic                     r_inc;
  logic                     w_next_inc;
  logic [PENDING_WIDTH-1:0] r_pending;
  logic [PENDING_WIDTH-1:0] w_next_pending;
  logic [PENDING_WIDTH:0]   w_add;
  logic [PENDING_WIDTH:0]   w_sum;
  logic                     w_accept;
  logic                     r_dropped;
  logic                     w_next_dropped;

  // Worst-case headroom: room for a full event regardless of what is offered.
`ifdef SCORE_SATURATE_EN
  assign addReady = 1'b1;
`else
  assign addReady = (({1'b0, r_pending} + PTS_MAX_W) <= PEND_MAX_W);
`endif

  assign w_accept  = addValid & addReady;
  assign incEnable = r_inc;
  assign pending   = r_pending;
  assign busy      = (r_pending != {PENDING_WIDTH{1'b0}}) || (r_state == ST_WAIT);
`ifdef SCORE_SATURATE_EN
  assign pointsDropped = r_dropped;
`endif

  // Next-state and pulse decision
  always_comb begin
    w_next_state = r_state;
    w_next_inc   = 1'b0;
    case (r_state)
      ST_ARM: begin
        if ((r_pending != {PENDING_WIDTH{1'b0}}) && counterReady) begin
          w_next_state = ST_WAIT;
          w_next_inc   = 1'b1;
        end else begin
          w_next_state = ST_ARM;
        end
      end
      ST_WAIT: begin
        if (counterReady) begin
          w_next_state = ST_ARM;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      default: begin
        w_next_state = ST_ARM;
      end
    endcase
  end

  // Accumulator: issue is subtracted before any clamp so a same-edge pulse frees a slot.
  always_comb begin
    w_add          = {(PENDING_WIDTH+1){1'b0}};
    w_next_dropped = r_dropped;
    if (w_accept) begin
      w_add = (PENDING_WIDTH+1)'(addPoints);
    end else begin
      w_add = {(PENDING_WIDTH+1){1'b0}};
    end
    w_sum = {1'b0, r_pending} + w_add - (PENDING_WIDTH+1)'(w_next_inc);
    if (w_sum > PEND_MAX_W) begin
      w_next_pending = PEND_MAX;
      w_next_dropped = 1'b1;
    end else begin
      w_next_pending = w_sum[PENDING_WIDTH-1:0];
    end
  end

  // State, pulse and accumulator registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= ST_ARM;
      r_inc     <= 1'b0;
      r_pending <= {PENDING_WIDTH{1'b0}};
      r_dropped <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_inc     <= w_next_inc;
      r_pending <= w_next_pending;
      r_dropped <= w_next_dropped;
    end
  end

endmodule

// File: tb/tb_score_increment_sequencer.sv
// Randomised and directed bench for score_increment_sequencer with a cycle-level scoreboard.
module tb_score_increment_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       addValid = 1'b1;
  logic [3:0] addPoints = 4'd5;
  logic       addReady;
  logic       counterReady = 1'b1;
  logic       incEnable;
  logic [7:0] pending;
  logic       busy;
  logic       pointsDropped;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int pend;
    bit inc;
    bit rdy;
    bit bsy;
    bit drop;
  } exp_t;

  exp_t exp_q[$];

  // Model state: points owed, whether a pulse still waits for the updater, drop flag
  int m_pend = 0;
  bit m_wait = 1'b0;
  bit m_drop = 1'b0;
  int m_accepted = 0;
  int dut_pulses = 0;

  score_increment_sequencer dut (
    .clock(clock),
    .reset(reset),
    .addValid(addValid),
    .addPoints(addPoints),
    .addReady(addReady),
    .counterReady(counterReady),
    .incEnable(incEnable),
    .pending(pending),
`ifdef SCORE_SATURATE_EN
    .pointsDropped(pointsDropped),
`endif
    .busy(busy)
  );

`ifndef SCORE_SATURATE_EN
  assign pointsDropped = 1'b0;
`endif

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit model_ready(input int p);
`ifdef SCORE_SATURATE_EN
    return 1'b1;
`else
    return (p + 15) <= 255;
`endif
  endfunction

  // Reference model: advances on each edge from the inputs the bench drove
  initial begin
    exp_t e;
    bit fire;
    bit acc;
    int sum;
    forever begin
      @(posedge clock);
      if (!reset) begin
        m_pend = 0;
        m_wait = 1'b0;
        m_drop = 1'b0;
        fire   = 1'b0;
      end else begin
        fire = !m_wait && (m_pend > 0) && counterReady;
        acc  = addValid && model_ready(m_pend);
        sum  = m_pend + (acc ? int'(addPoints) : 0) - (fire ? 1 : 0);
        if (acc) m_accepted += int'(addPoints);
        if (sum > 255) begin
          sum    = 255;
          m_drop = 1'b1;
        end
        m_pend = sum;
        if (fire) m_wait = 1'b1;
        else if (counterReady) m_wait = 1'b0;
      end
      e.pend = m_pend;
      e.inc  = fire;
      e.rdy  = model_ready(m_pend);
      e.bsy  = (m_pend != 0) || m_wait;
      e.drop = m_drop;
      exp_q.push_back(e);
    end
  end

  // Monitor: compares DUT outputs against the oldest expected entry each cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pending", int'(pending), e.pend);
        check("incEnable", int'(incEnable), int'(e.inc));
        check("addReady", int'(addReady), int'(e.rdy));
        check("busy", int'(busy), int'(e.bsy));
`ifdef SCORE_SATURATE_EN
        check("pointsDropped", int'(pointsDropped), int'(e.drop));
`endif
        if (reset && incEnable) dut_pulses++;
      end
    end
  end

  task automatic cyc(input bit v, input int p, input bit c);
    addValid     = v;
    addPoints    = 4'(p);
    counterReady = c;
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 700; i++) begin
      if (m_pend == 0 && !m_wait) break;
      cyc(1'b0, 0, 1'b1);
    end
    check("drain_timeout", (m_pend == 0 && !m_wait) ? 1 : 0, 1);
  endtask

  initial begin
    // Reset held with an event offered
    repeat (3) begin
      @(posedge clock);
      #1;
      check("reset_pending", int'(pending), 0);
      check("reset_inc", int'(incEnable), 0);
      check("reset_busy", int'(busy), 0);
    end
    reset = 1'b1;

    // Single three-point event
    cyc(1'b1, 3, 1'b1);
    check("single_accept", int'(pending), 3);
    repeat (8) cyc(1'b0, 0, 1'b1);

    // Pacing with the updater not ready
    cyc(1'b1, 2, 1'b0);
    repeat (10) cyc(1'b0, 0, 1'b0);
    check("pacing_hold", int'(pending), 2);
    cyc(1'b0, 0, 1'b1);
    check("pacing_pulse", int'(incEnable), 1);
    drain();

    // Add on the pulse edge
    cyc(1'b1, 4, 1'b0);
    cyc(1'b1, 7, 1'b1);
    check("simultaneous", int'(pending), 10);
    drain();

    // Fill to the headroom limit
    repeat (16) cyc(1'b1, 15, 1'b0);
    cyc(1'b1, 1, 1'b0);
    check("full_pending", int'(pending), 241);
`ifndef SCORE_SATURATE_EN
    check("full_ready", int'(addReady), 0);
    cyc(1'b1, 5, 1'b0);
    cyc(1'b0, 0, 1'b1);
    check("after_pulse", int'(pending), 240);
    check("ready_again", int'(addReady), 1);
`endif
    drain();

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      cyc(($urandom_range(0, 9) < 4), int'($urandom_range(0, 15)),
          ($urandom_range(0, 9) < 7));
    end
    addValid = 1'b0;
    drain();
    @(negedge clock);
    @(negedge clock);
`ifndef SCORE_SATURATE_EN
    check("pulses_vs_points", dut_pulses, m_accepted);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
